// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's memory, decode and redirect signals.
// The fetch unit takes the master modport; memory/decode/ALU side take slave.
interface fetch_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                    redirect;
  logic [XLEN-1:0]         redirect_pc;
  logic                    imem_req;
  logic [XLEN-1:0]         imem_addr;
  logic                    imem_ready;
  logic                    imem_rvalid;
  logic [31:0]             imem_rdata;
  logic                    inst_valid;
  logic [31:0]             inst;
  logic [XLEN-1:0]         inst_pc;
  logic                    inst_ready;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    input  redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, count
  );

  modport slave (
    output redirect, redirect_pc, imem_ready, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: request/response memory handshake, prefetch
// queue toward decode, and flush-on-redirect with stale-response dropping.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 1,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t          DEPTH_C = cnt_t'(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetchPc_q, respPc_q;
  cnt_t            inflight_q, drop_q, count_q;
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [31:0]     instMem_q [DEPTH];
  logic [XLEN-1:0] pcMem_q   [DEPTH];

  logic            rspValid, reqFire, push, pop, headValid, reqOk;
  logic [CW:0]     committed;

  // Issue only while every outstanding kept response is guaranteed a slot.
  always_comb begin
    rspValid  = bus.imem_rvalid && (inflight_q != '0);
    committed = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
    headValid = (count_q != '0);
    reqOk     = !reset && !bus.redirect && (inflight_q < DEPTH_C) && (committed < DEPTH_X);
    reqFire   = reqOk && bus.imem_ready;
    push      = rspValid && !bus.redirect && (drop_q == '0);
    pop       = headValid && bus.inst_ready && !bus.redirect;
  end

  assign bus.imem_req   = reqOk;
  assign bus.imem_addr  = fetchPc_q;
  assign bus.inst_valid = headValid;
  assign bus.inst       = headValid ? instMem_q[rdPtr_q] : NOP_INST;
  assign bus.inst_pc    = pcMem_q[rdPtr_q];
  assign bus.count      = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchPc_q  <= RESET_PC;
      respPc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instMem_q[i] <= NOP_INST;
        pcMem_q[i]   <= RESET_PC;
      end
    end else if (bus.redirect) begin
      // Everything still in flight now belongs to the abandoned path.
      fetchPc_q  <= bus.redirect_pc;
      respPc_q   <= bus.redirect_pc;
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      inflight_q <= inflight_q - cnt_t'(rspValid);
      drop_q     <= inflight_q - cnt_t'(rspValid);
    end else begin
      if (reqFire) begin
        fetchPc_q <= fetchPc_q + STEP;
      end
      inflight_q <= inflight_q + cnt_t'(reqFire) - cnt_t'(rspValid);
      if (rspValid && (drop_q != '0)) begin
        drop_q <= drop_q - cnt_t'(1);
      end
      if (push) begin
        instMem_q[wrPtr_q] <= bus.imem_rdata;
        pcMem_q[wrPtr_q]   <= respPc_q;
        wrPtr_q            <= wrPtr_q + 1'b1;
        respPc_q           <= respPc_q + STEP;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  noOverflow: assert property (@(posedge clock) disable iff (reset)
    !(push && (count_q == DEPTH_C) && !bus.inst_ready));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with an in-order memory model and a
// queue-based reference of which fetched words decode should see, in order.
module tb_fetch_unit;
  localparam int          XLEN  = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          stale;
  } req_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus();

  fetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(1), .NOP_INST(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          memLat = 1;
  req_t        memQ[$];
  logic [15:0] fifoQ[$];
  logic [15:0] nextAddr;

  function automatic logic [31:0] memWord(input logic [15:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic modelReset();
    memQ.delete();
    fifoQ.delete();
    nextAddr = RPC;
  endtask

  // One clock cycle: drive inputs after negedge, check, advance the model.
  task automatic applyStimulus(input bit redir, input logic [15:0] rpc, input bit instRdy,
                               input bit memRdy, input bit stray);
    bit   rsp, expReq;
    int   live;
    req_t h;
    rsp = (memQ.size() > 0) && (memQ[0].due <= cyc);
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.inst_ready  = instRdy;
    bus.imem_ready  = memRdy;
    bus.imem_rvalid = rsp | stray;
    bus.imem_rdata  = rsp ? memWord(memQ[0].addr) : 32'hDEAD_BEEF;
    #1;
    live = 0;
    foreach (memQ[i]) if (!memQ[i].stale) live++;
    expReq = !redir && (memQ.size() < DEPTH) && (fifoQ.size() + live < DEPTH);
    checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
    checkOutput("imem_addr", 32'(bus.imem_addr), 32'(nextAddr));
    checkOutput("inst_valid", 32'(bus.inst_valid), 32'(fifoQ.size() > 0));
    checkOutput("count", 32'(bus.count), 32'(fifoQ.size()));
    if (fifoQ.size() > 0) begin
      checkOutput("inst", bus.inst, memWord(fifoQ[0]));
      checkOutput("inst_pc", 32'(bus.inst_pc), 32'(fifoQ[0]));
    end else begin
      checkOutput("inst_nop", bus.inst, NOP);
    end
    if (redir) begin
      if (rsp) void'(memQ.pop_front());
      foreach (memQ[i]) memQ[i].stale = 1'b1;
      fifoQ.delete();
      nextAddr = rpc;
    end else begin
      if ((fifoQ.size() > 0) && instRdy) void'(fifoQ.pop_front());
      if (rsp) begin
        h = memQ.pop_front();
        if (!h.stale) fifoQ.push_back(h.addr);
      end
      if (expReq && memRdy) begin
        memQ.push_back('{addr: nextAddr, due: cyc + memLat, stale: 1'b0});
        nextAddr = nextAddr + 16'd1;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    checkOutput({tag, "_addr"}, 32'(bus.imem_addr), 32'(RPC));
    checkOutput({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    checkOutput({tag, "_inst"}, bus.inst, NOP);
    checkOutput({tag, "_pc"}, 32'(bus.inst_pc), 32'(RPC));
    checkOutput({tag, "_count"}, 32'(bus.count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    bit rspNow;
    reset = 1'b1;
    bus.redirect = 1'b0;  bus.redirect_pc = '0;  bus.inst_ready = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    modelReset();
    #2;
    checkResetOutputs("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] streaming with 1-cycle memory");
    memLat = 1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] decode stall then release");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] redirect with three in flight");
    memLat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (memQ.size() == 3) found = 1'b1;
      else applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    end
    checkOutput("reach_inflight3", 32'(found), 32'd1);
    if (found) applyStimulus(1'b1, 16'h0040, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] redirect with response and pop at count 2");
    memLat = 2;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      rspNow = (memQ.size() > 0) && (memQ[0].due <= cyc);
      if (fifoQ.size() == 2 && rspNow) begin
        found = 1'b1;
        applyStimulus(1'b1, 16'h0123, 1'b1, 1'b1, 1'b0);
      end else begin
        applyStimulus(1'b0, '0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 1'b0);
      end
    end
    checkOutput("reach_redirect_pop", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-stream");
    memLat = 3;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (fifoQ.size() >= 2 && memQ.size() >= 1) found = 1'b1;
      else applyStimulus(1'b0, '0, $urandom_range(0, 2) == 0, 1'b1, 1'b0);
    end
    checkOutput("reach_midstream", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    bus.redirect = 1'b0; bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b0;
    #1;
    checkResetOutputs("async");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] address wrap at top of 16-bit space");
    memLat = 1;
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) memLat = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 19) == 0, 16'($urandom), $urandom_range(0, 99) < 70,
                    $urandom_range(0, 99) < 75, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
